// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: funct3 size/sign
// encodings, FSM states, write-back select codes and small lane helpers.
package data_mem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Write-back mux selects; loads return through MEM_TO_REG_MEM.
  localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MEM = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC4 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Halfwords only look at addr[1]; words always use the whole bus.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_repl(input logic [2:0] f3, input logic [31:0] data);
    case (f3[1:0])
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_load_extend.sv
// Load lane selection and sign/zero extension. Purely combinational so a
// pipelined core can drop it into its memory stage unchanged.
module data_mem_responder_load_extend
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed byte/halfword, then extend according to funct3.
  always_comb begin
    case (offset)
      2'd0:    lane_b = raw[7:0];
      2'd1:    lane_b = raw[15:8];
      2'd2:    lane_b = raw[23:16];
      default: lane_b = raw[31:24];
    endcase
    lane_h = offset[1] ? raw[31:16] : raw[15:0];
    data   = '0;
    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_W:    data = raw;
      F3_BU:   data = {24'd0, lane_b};
      F3_HU:   data = {16'd0, lane_h};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: turns single-cycle core load/store requests into a
// req/ready bus transaction and stalls the core until it completes.
// Optional build macro MISALIGN_TRAP_EN: misaligned H/W accesses are refused
// with a bus_err pulse instead of being issued with low address bits ignored.
//
// state     | meaning
// ST_IDLE   | waiting for mem_read/mem_write; latches the request
// ST_ACCESS | dmem_req held, waiting for dmem_ready or timeout
// ST_DONE   | one cycle with stall low so the core retires the instruction
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              bus_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [3:0]        dmem_be,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ready
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [31:0]     load_data;
  logic            req, trap_misalign;
  logic            start_access, complete, raise_err;

  // A simultaneous read and write is served as a write.
  assign req = mem_read | mem_write;

`ifdef MISALIGN_TRAP_EN
  assign trap_misalign = misaligned(funct3, addr[1:0]);
`else
  assign trap_misalign = 1'b0;
`endif

  data_mem_responder_load_extend u_load_extend (
    .raw    (dmem_rdata),
    .funct3 (f3_q),
    .offset (off_q),
    .data   (load_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, stall and bus request; refused requests skip the bus entirely.
  always_comb begin
    state_d      = state_q;
    start_access = 1'b0;
    complete     = 1'b0;
    raise_err    = 1'b0;
    stall        = 1'b0;
    dmem_req     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          stall = 1'b1;
          if (!f3_legal(funct3, mem_write) || trap_misalign) begin
            raise_err = 1'b1;
            state_d   = ST_DONE;
          end else begin
            start_access = 1'b1;
            state_d      = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        stall    = 1'b1;
        dmem_req = 1'b1;
        // A completion on the final timer cycle still wins over the timeout.
        if (dmem_ready) begin
          complete = 1'b1;
          state_d  = ST_DONE;
        end else if (timer_q == TIMER_LAST) begin
          raise_err = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, access timer, load capture and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q    <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      dmem_we    <= 1'b0;
      dmem_be    <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rdata      <= '0;
      bus_err    <= 1'b0;
    end else begin
      bus_err <= raise_err;
      if (start_access) begin
        timer_q    <= '0;
        f3_q       <= funct3;
        off_q      <= addr[1:0];
        dmem_we    <= mem_write;
        dmem_be    <= byte_en(funct3, addr[1:0]);
        dmem_addr  <= {addr[ADDR_W-1:2], 2'b00};
        dmem_wdata <= lane_repl(funct3, wdata);
      end else if (state_q == ST_ACCESS && !dmem_ready) begin
        timer_q <= timer_q + 1'b1;
      end
      if (complete && !dmem_we) rdata <= load_data;
      else if (raise_err)       rdata <= '0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, hand sequences for reset
// and stray ready, then random transactions against a byte-level model.
module tb_data_mem_responder;

  localparam int T = 8;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        stall, bus_err, dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .bus_err(bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready)
  );

  typedef struct {
    bit          rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rword;
    int          delay;       // ACCESS cycle index carrying dmem_ready, -1 = never
    bit          exp_access, exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    bit          exp_err;
    int          exp_stall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(bit rd, bit wr, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                             logic [31:0] rw, int dly, bit acc, bit we, logic [3:0] be,
                             logic [31:0] ea, logic [31:0] ewd, logic [31:0] erd, bit err, int st);
    vec_t r;
    r.rd = rd; r.wr = wr; r.f3 = f3; r.addr = a; r.wdata = wd; r.rword = rw; r.delay = dly;
    r.exp_access = acc; r.exp_we = we; r.exp_be = be; r.exp_addr = ea; r.exp_wdata = ewd;
    r.exp_rdata = erd; r.exp_err = err; r.exp_stall = st;
    return r;
  endfunction

  // Reference: derive the whole transaction outcome from size/sign rules.
  function automatic vec_t model(input vec_t t);
    vec_t r = t;
    int nb = 4, a4, lane;
    bit sgn = 1'b0, legal = 1'b1, misal, tmo;
    bit [63:0] m, val;
    if (t.wr) begin
      case (t.f3)
        3'd0: nb = 1;
        3'd1: nb = 2;
        3'd2: nb = 4;
        default: legal = 1'b0;
      endcase
    end else begin
      case (t.f3)
        3'd0: begin nb = 1; sgn = 1'b1; end
        3'd1: begin nb = 2; sgn = 1'b1; end
        3'd2: nb = 4;
        3'd4: nb = 1;
        3'd5: nb = 2;
        default: legal = 1'b0;
      endcase
    end
    a4    = int'(t.addr % 32'd4);
    lane  = a4 - (a4 % nb);
    misal = (a4 % nb) != 0;
    r.exp_access = legal && !(TRAP && misal);
    tmo          = r.exp_access && !(t.delay >= 0 && t.delay < T);
    r.exp_err    = !r.exp_access || tmo;
    r.exp_stall  = 1 + (r.exp_access ? (tmo ? T : t.delay + 1) : 0);
    r.exp_we     = t.wr;
    r.exp_be     = 4'(((1 << nb) - 1) << lane);
    r.exp_addr   = t.addr & ~32'h3;
    if (nb == 1)      r.exp_wdata = (t.wdata & 32'hFF) * 32'h01010101;
    else if (nb == 2) r.exp_wdata = (t.wdata & 32'hFFFF) * 32'h00010001;
    else              r.exp_wdata = t.wdata;
    r.exp_rdata = 32'd0;
    if (!r.exp_err && !t.wr) begin
      m   = (64'd1 << (8 * nb)) - 64'd1;
      val = ({32'd0, t.rword} >> (8 * lane)) & m;
      if (sgn && val[8*nb-1]) val = val | ~m;
      r.exp_rdata = val[31:0];
    end
    return r;
  endfunction

  // Play one request like the core would and check everything it observes.
  task automatic do_txn(input vec_t t, input string tag);
    int acc_idx = 0, stall_cnt = 0;
    bit done = 1'b0, err_early = 1'b0;
    @(posedge clk); #1;
    mem_read = t.rd; mem_write = t.wr; funct3 = t.f3; addr = t.addr;
    wdata = t.wdata; dmem_rdata = t.rword; dmem_ready = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stall) begin
        stall_cnt++;
        if (bus_err) err_early = 1'b1;
        if (dmem_req) begin
          if (acc_idx == 0) begin
            chk({tag, " we"},   dmem_we,   t.exp_we);
            chk({tag, " be"},   dmem_be,   t.exp_be);
            chk({tag, " addr"}, dmem_addr, t.exp_addr);
            if (t.exp_we) chk({tag, " wdata"}, dmem_wdata, t.exp_wdata);
          end
          dmem_ready = (t.delay == acc_idx);
          acc_idx++;
        end else dmem_ready = 1'b0;
      end else begin
        done = 1'b1;
        dmem_ready = 1'b0;
        chk({tag, " bus_err"}, bus_err, t.exp_err);
        chk({tag, " req_done"}, dmem_req, 1'b0);
        if ((t.rd && !t.wr) || t.exp_err) chk({tag, " rdata"}, rdata, t.exp_rdata);
        mem_read = 1'b0; mem_write = 1'b0;
      end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL %s done: stall never released within 40 cycles", tag);
      mem_read = 1'b0; mem_write = 1'b0; dmem_ready = 1'b0;
    end
    chk({tag, " stall_cycles"}, stall_cnt, t.exp_stall);
    chk({tag, " accessed"}, acc_idx > 0, t.exp_access);
    chk({tag, " err_early"}, err_early, 1'b0);
  endtask

  vec_t tbl[15];

  initial begin
    tbl[0]  = v(1,0,3'd2,'h100,0,'hDEADBEEF,2, 1,0,4'hF,'h100,0,'hDEADBEEF,0,4);
    tbl[1]  = v(1,0,3'd0,'h103,0,'h80112233,0, 1,0,4'h8,'h100,0,'hFFFFFF80,0,2);
    tbl[2]  = v(1,0,3'd4,'h103,0,'h80112233,0, 1,0,4'h8,'h100,0,'h00000080,0,2);
    tbl[3]  = v(0,1,3'd1,'h202,'h0000ABCD,0,1, 1,1,4'hC,'h200,'hABCDABCD,0,0,3);
    tbl[4]  = v(1,0,3'd1,'h102,0,'h80112233,3, 1,0,4'hC,'h100,0,'hFFFF8011,0,5);
    tbl[5]  = v(1,0,3'd5,'h100,0,'h80112233,0, 1,0,4'h3,'h100,0,'h00002233,0,2);
    tbl[6]  = v(0,1,3'd2,'h300,'h12345678,0,0, 1,1,4'hF,'h300,'h12345678,0,0,2);
    tbl[7]  = v(0,1,3'd0,'h301,'hFFFF12A5,0,0, 1,1,4'h2,'h300,'hA5A5A5A5,0,0,2);
    tbl[8]  = v(1,0,3'd3,'h010,0,'h55,0, 0,0,0,0,0,0,1,1);
    tbl[9]  = v(0,1,3'd4,'h010,'h77,0,0, 0,1,0,0,0,0,1,1);
    tbl[10] = v(1,1,3'd2,'h040,'h11223344,0,0, 1,1,4'hF,'h040,'h11223344,0,0,2);
    tbl[12] = v(1,0,3'd2,'h008,0,'h5A5A5A5A,-1, 1,0,4'hF,'h008,0,0,1,1+T);
    tbl[14] = v(1,0,3'd2,'h020,0,'h01234567,T-1, 1,0,4'hF,'h020,0,'h01234567,0,1+T);
    if (TRAP) begin
      tbl[11] = v(1,0,3'd2,'h101,0,'hCAFEF00D,0, 0,0,0,0,0,0,1,1);
      tbl[13] = v(1,0,3'd1,'h103,0,'h7FFF0000,1, 0,0,0,0,0,0,1,1);
    end else begin
      tbl[11] = v(1,0,3'd2,'h101,0,'hCAFEF00D,0, 1,0,4'hF,'h100,0,'hCAFEF00D,0,2);
      tbl[13] = v(1,0,3'd1,'h103,0,'h7FFF0000,1, 1,0,4'hC,'h100,0,'h00007FFF,0,3);
    end

    rst = 1'b1; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; wdata = 0;
    dmem_rdata = 0; dmem_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst rdata", rdata, 0);
    chk("rst stall", stall, 0);
    chk("rst bus_err", bus_err, 0);
    chk("rst req", dmem_req, 0);
    chk("rst we", dmem_we, 0);
    chk("rst be", dmem_be, 0);
    chk("rst addr", dmem_addr, 0);
    chk("rst wdata", dmem_wdata, 0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) do_txn(tbl[i], $sformatf("tbl%0d", i));

    // Stray dmem_ready while idle must change nothing.
    @(posedge clk); #1 dmem_ready = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("stray req", dmem_req, 0);
    chk("stray stall", stall, 0);
    @(posedge clk); #1 dmem_ready = 1'b0;
    @(negedge clk);
    chk("stray bus_err", bus_err, 0);
    chk("stray rdata", rdata, 32'h01234567);

    // Asynchronous reset in the middle of an access.
    @(posedge clk); #1 mem_read = 1'b1; funct3 = 3'd2; addr = 32'h44;
    repeat (4) @(negedge clk);
    chk("mid req_before", dmem_req, 1);
    #2 rst = 1'b1; mem_read = 1'b0;
    #1;
    chk("mid req", dmem_req, 0);
    chk("mid stall", stall, 0);
    chk("mid rdata", rdata, 0);
    chk("mid be", dmem_be, 0);
    chk("mid addr", dmem_addr, 0);
    @(negedge clk); rst = 1'b0;
    do_txn(v(0,1,3'd0,'h45,'h0000003C,0,1, 1,1,4'h2,'h44,'h3C3C3C3C,0,0,3), "post_rst_sb");

    for (int i = 0; i < 80; i++) begin
      vec_t r;
      int kind = $urandom_range(0, 2);
      int d = $urandom_range(0, 9);
      r.rd = (kind != 1); r.wr = (kind != 0);
      r.f3 = 3'($urandom_range(0, 7));
      r.addr = $urandom & 32'h0000_0FFF;
      r.wdata = $urandom;
      r.rword = $urandom;
      r.delay = (d <= 5) ? d : (d <= 7) ? T - 1 : (d == 8) ? -1 : 2;
      do_txn(model(r), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
